regfile_ctrl: RTL and testbench
===============================

Name: regfile_ctrl

Overview:
- Sequences all write and stack traffic into the 8x32 register file.
- Arbitrates the single write port between three requesters: ALU writeback, load return, and call-stack push.
- Owns the stack pointer and call depth, and runs pop (return-address read) as a small state machine over the registered read port.
- Sits between the execute/memory stages and the register file; drives its write-enable, write-select, write-data and one read-select.

Parameters:
DW, 32, register data width
AW, 3, register address width
PCW, 8, program-counter width
STACK_BASE, 7, highest register index; stack grows downward from here
STACK_DEPTH, 4, maximum live stack entries (registers 7..4)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
wb_valid  in  1  ALU writeback request
wb_ready  out  1  writeback accepted this cycle
wb_addr  in  AW  writeback target register
wb_data  in  DW  writeback data
ld_valid  in  1  load-return write request
ld_ready  out  1  load write accepted this cycle
ld_addr  in  AW  load target register
ld_data  in  DW  load data
push_req  in  1  call: push return address
pop_req  in  1  return: pop return address
push_pc  in  PCW  PC of the call instruction
stk_ready  out  1  push/pop accepted this cycle
pop_valid  out  1  pop_data valid, one-cycle pulse
pop_data  out  PCW  popped return address, low PCW bits of the entry
stk_overflow  out  1  one-cycle pulse: push rejected, stack full
stk_underflow  out  1  one-cycle pulse: pop rejected, stack empty
rf_we  out  1  register-file write enable
rf_ws  out  AW  register-file write select
rf_wd  out  DW  register-file write data
rf_rs  out  AW  register-file read select for pop
rf_rd  in  DW  register-file read data, registered one cycle after rf_rs
sp_out  out  AW  current stack pointer, the next free slot

Behaviour:
- Reset (reset low, async):
  - All outputs 0, except sp_out = STACK_BASE.
  - count = 0; round-robin pointer favours wb; FSM = IDLE.
- Handshakes:
  - A transfer occurs at the posedge where valid (or req) and the matching ready are both high.
  - Requesters hold valid and payload stable until accepted.
  - Ready signals are combinational from the current-cycle grant.
- Write-port priority:
  - Accepted push has highest priority.
  - wb and ld share the port round-robin: on contention, grant the one not granted last contention.
  - An uncontended grant does not move the pointer.
  - At most one of wb_ready, ld_ready, or a push write per cycle.
- Write path: registered, 1-cycle latency. On accept, next cycle rf_we = 1 with rf_ws/rf_wd = winner address/data; otherwise rf_we = 0.
- Push (accepted, count < STACK_DEPTH):
  - Next cycle: rf_we = 1, rf_ws = sp, rf_wd = zero-extended push_pc + 1 (mod 2^PCW).
  - sp decrements and count increments.
- Push when count == STACK_DEPTH:
  - stk_ready = 1 (consumed), no write, sp unchanged.
  - stk_overflow pulses the next cycle.
- Pop: FSM IDLE -> POP_RD -> POP_RSP -> IDLE.
  - IDLE, pop_req with count > 0: stk_ready = 1; at the edge, sp increments, count decrements, rf_rs = new sp, go to POP_RD.
  - POP_RD: register file samples rf_rs; go to POP_RSP.
  - POP_RSP: pop_valid = 1, pop_data = rf_rd[PCW-1:0]; go to IDLE.
  - Total latency: accept edge + 2 cycles.
- Pop when count == 0: stk_ready = 1, no state change, stk_underflow pulses the next cycle.
- While FSM != IDLE: stk_ready = 0 (push and pop both stall). wb/ld writes continue normally.
- push_req and pop_req together: push wins; pop stays pending.
- Writes from wb/ld into stack registers are not blocked; correctness there is the compiler's responsibility.
- Reset mid-pop: FSM returns to IDLE, pop_valid never asserts, sp/count restored to empty.
- sp, count and ready outputs never go X. All counters saturate via the full/empty checks and never wrap.

Decomposition:
- Package regfile_pkg: DW, AW, PCW, STACK_BASE, STACK_DEPTH, FSM state enum (IDLE, POP_RD, POP_RSP), requester-ID constants (REQ_WB, REQ_LD, REQ_STK).
- One sub-module, rr_arb2: two-way round-robin arbiter with a registered last-grant pointer, used for wb/ld.
- FSM, stack pointer and write mux stay in regfile_ctrl.

Test Plan:
- Reset release: sp_out = 7, rf_we = 0, all ready = 0 while idle, pop_valid = 0.
- wb_valid and ld_valid held 4 cycles (addr 1/2, data 0xA/0xB): grants alternate wb, ld, wb, ld; rf_we writes r1 = 0xA, r2 = 0xB, each one cycle after accept.
- Push push_pc = 0x10, then 0x20: writes r7 = 0x11, r6 = 0x21; sp_out = 5. Pop returns pop_data = 0x21 two cycles after accept, then 0x11; sp_out back to 7.
- Four pushes, then a fifth: fifth gets stk_overflow pulse, no rf_we, sp_out stays 3. Pop on empty stack after reset: stk_underflow pulse, FSM stays IDLE.
- Same cycle push_req, pop_req and wb_valid: push granted and written first, wb stalls one cycle, pop accepted the following cycle.
- Assert reset during POP_RD: no pop_valid; after release sp_out = 7 and a new push writes r7.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the register-file write/stack controller.
//   DW / AW / PCW      : data, register-address and program-counter widths
//   STACK_BASE         : highest register index; the call stack grows down
//   STACK_DEPTH        : number of registers the stack may occupy
//   CW                 : width of the live-entry counter (holds 0..STACK_DEPTH)
//   IDLE/POP_RD/POP_RSP: pop state machine encodings
//   req_id_e           : which requester owns the write port this cycle
//   ret_addr()         : return address written by a call-stack push
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DW          = 32;
    localparam int AW          = 3;
    localparam int PCW         = 8;
    localparam int STACK_BASE  = 7;
    localparam int STACK_DEPTH = 4;
    localparam int CW          = $clog2(STACK_DEPTH + 1);

    // Pop sequencer states.
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] POP_RD  = 2'd1;
    localparam logic [1:0] POP_RSP = 2'd2;

    // Write-port owner.
    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_WB   = 2'd1,
        REQ_LD   = 2'd2,
        REQ_STK  = 2'd3
    } req_id_e;

    // A call pushes the address of the instruction after the call.
    // The increment wraps inside PCW bits before zero-extension.
    function automatic logic [DW-1:0] ret_addr(input logic [PCW-1:0] pc);
        logic [PCW-1:0] nxt;
        nxt = pc + PCW'(1);
        return {{(DW-PCW){1'b0}}, nxt};
    endfunction

endpackage

// File: rtl/regfile_ctrl_if.sv
// -----------------------------------------------------------------------------
// regfile_ctrl_if
// Bundles every request/response and register-file signal of regfile_ctrl.
//   slave  modport : the controller's view (requests in, readies/rf bus out)
//   master modport : the surrounding pipeline + register file view
// Signals:
//   wb_*   ALU writeback request/accept, target address and data
//   ld_*   load-return request/accept, target address and data
//   push_req/pop_req/push_pc/stk_ready  call-stack requests and accept
//   pop_valid/pop_data                  popped return address
//   stk_overflow/stk_underflow          rejected push/pop pulses
//   rf_we/rf_ws/rf_wd                   register-file write port
//   rf_rs/rf_rd                         register-file read port (registered)
//   sp_out                              current stack pointer (next free slot)
// -----------------------------------------------------------------------------
interface regfile_ctrl_if;
    import regfile_pkg::*;

    logic           wb_valid;
    logic           wb_ready;
    logic [AW-1:0]  wb_addr;
    logic [DW-1:0]  wb_data;

    logic           ld_valid;
    logic           ld_ready;
    logic [AW-1:0]  ld_addr;
    logic [DW-1:0]  ld_data;

    logic           push_req;
    logic           pop_req;
    logic [PCW-1:0] push_pc;
    logic           stk_ready;
    logic           pop_valid;
    logic [PCW-1:0] pop_data;
    logic           stk_overflow;
    logic           stk_underflow;

    logic           rf_we;
    logic [AW-1:0]  rf_ws;
    logic [DW-1:0]  rf_wd;
    logic [AW-1:0]  rf_rs;
    logic [DW-1:0]  rf_rd;
    logic [AW-1:0]  sp_out;

    modport slave (
        input  wb_valid, wb_addr, wb_data,
        input  ld_valid, ld_addr, ld_data,
        input  push_req, pop_req, push_pc,
        input  rf_rd,
        output wb_ready, ld_ready, stk_ready,
        output pop_valid, pop_data, stk_overflow, stk_underflow,
        output rf_we, rf_ws, rf_wd, rf_rs, sp_out
    );

    modport master (
        output wb_valid, wb_addr, wb_data,
        output ld_valid, ld_addr, ld_data,
        output push_req, pop_req, push_pc,
        output rf_rd,
        input  wb_ready, ld_ready, stk_ready,
        input  pop_valid, pop_data, stk_overflow, stk_underflow,
        input  rf_we, rf_ws, rf_wd, rf_rs, sp_out
    );

endinterface

// File: rtl/regfile_ctrl_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with a registered preference pointer.
//   clk, reset : clock and asynchronous active-low reset
//   en         : the shared resource is free this cycle
//   req_a/b    : requests (a = ALU writeback, b = load return)
//   gnt_a/b    : combinational one-hot-or-zero grants
// The pointer only moves when both request in a cycle the resource is free,
// so a lone requester never disturbs the fairness order.
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    logic prefer_b_reg;
    logic prefer_b_next;
    logic contend;

    assign contend = req_a & req_b;

    always_comb begin
        gnt_a         = 1'b0;
        gnt_b         = 1'b0;
        prefer_b_next = prefer_b_reg;
        if (en) begin
            if (contend) begin
                if (prefer_b_reg) begin
                    gnt_b = 1'b1;
                end else begin
                    gnt_a = 1'b1;
                end
                // Winner of this contention goes to the back of the line.
                prefer_b_next = ~prefer_b_reg;
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prefer_b_reg <= 1'b0;
        end else begin
            prefer_b_reg <= prefer_b_next;
        end
    end

endmodule

// File: rtl/regfile_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_ctrl
// Write-port sequencer and call-stack owner for the 8x32 register file.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   bus    : regfile_ctrl_if.slave -- wb/ld write requests, call-stack
//            push/pop, and the register-file write/read ports
// Write port: a writing push wins outright; wb and ld share what is left
// through rr_arb2. The winner is registered and presented on rf_we/ws/wd
// one cycle after acceptance.
// Stack: sp points at the next free slot and moves down from STACK_BASE.
// A pop reads through the registered read port: accept (sp++, rf_rs = new sp),
// POP_RD (register file samples rf_rs), POP_RSP (rf_rd is returned).
// -----------------------------------------------------------------------------
module regfile_ctrl (
    input  logic           clk,
    input  logic           reset,
    regfile_ctrl_if.slave  bus
);
    import regfile_pkg::*;

    logic [1:0]    state_reg, state_next;
    logic [AW-1:0] sp_reg,    sp_next;
    logic [CW-1:0] count_reg, count_next;
    logic [AW-1:0] rs_reg,    rs_next;
    logic          we_reg,    we_next;
    logic [AW-1:0] ws_reg,    ws_next;
    logic [DW-1:0] wd_reg,    wd_next;
    logic          ovf_reg,   ovf_next;
    logic          unf_reg,   unf_next;

    logic          stk_idle;
    logic          stk_full;
    logic          stk_empty;
    logic          push_acc;
    logic          pop_acc;
    logic          push_wr;
    logic          pop_go;
    logic          wb_gnt;
    logic          ld_gnt;
    req_id_e       wsrc;
    logic          unused_rd_hi;

    assign stk_idle  = (state_reg == IDLE);
    assign stk_full  = (count_reg == CW'(STACK_DEPTH));
    assign stk_empty = (count_reg == '0);

    // Stack requests are only taken in IDLE; push beats a simultaneous pop,
    // which simply stays pending. Rejected (full/empty) requests are still
    // consumed so the requester can move on.
    assign push_acc = stk_idle & bus.push_req;
    assign pop_acc  = stk_idle & bus.pop_req & ~bus.push_req;
    assign push_wr  = push_acc & ~stk_full;
    assign pop_go   = pop_acc & ~stk_empty;

    // A full-stack push writes nothing, so it does not steal the port.
    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (~push_wr),
        .req_a (bus.wb_valid),
        .req_b (bus.ld_valid),
        .gnt_a (wb_gnt),
        .gnt_b (ld_gnt)
    );

    assign bus.wb_ready  = wb_gnt;
    assign bus.ld_ready  = ld_gnt;
    assign bus.stk_ready = push_acc | pop_acc;

    // ------------------------------------------------------------------
    // Write-port owner and next write
    // ------------------------------------------------------------------
    always_comb begin
        wsrc = REQ_NONE;
        if (push_wr) begin
            wsrc = REQ_STK;
        end else if (wb_gnt) begin
            wsrc = REQ_WB;
        end else if (ld_gnt) begin
            wsrc = REQ_LD;
        end
    end

    always_comb begin
        we_next = 1'b0;
        ws_next = ws_reg;
        wd_next = wd_reg;
        case (wsrc)
            REQ_STK: begin
                we_next = 1'b1;
                ws_next = sp_reg;
                wd_next = ret_addr(bus.push_pc);
            end
            REQ_WB: begin
                we_next = 1'b1;
                ws_next = bus.wb_addr;
                wd_next = bus.wb_data;
            end
            REQ_LD: begin
                we_next = 1'b1;
                ws_next = bus.ld_addr;
                wd_next = bus.ld_data;
            end
            default: begin
                we_next = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stack pointer, depth and pop sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        sp_next    = sp_reg;
        count_next = count_reg;
        rs_next    = rs_reg;
        ovf_next   = push_acc & stk_full;
        unf_next   = pop_acc & stk_empty;
        case (state_reg)
            IDLE: begin
                if (push_wr) begin
                    sp_next    = sp_reg - AW'(1);
                    count_next = count_reg + CW'(1);
                end else if (pop_go) begin
                    // The entry just below the free slot is the top of stack.
                    sp_next    = sp_reg + AW'(1);
                    count_next = count_reg - CW'(1);
                    rs_next    = sp_reg + AW'(1);
                    state_next = POP_RD;
                end
            end
            POP_RD: begin
                state_next = POP_RSP;
            end
            POP_RSP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            sp_reg    <= AW'(STACK_BASE);
            count_reg <= '0;
            rs_reg    <= '0;
            we_reg    <= 1'b0;
            ws_reg    <= '0;
            wd_reg    <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sp_reg    <= sp_next;
            count_reg <= count_next;
            rs_reg    <= rs_next;
            we_reg    <= we_next;
            ws_reg    <= ws_next;
            wd_reg    <= wd_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.rf_we         = we_reg;
    assign bus.rf_ws         = ws_reg;
    assign bus.rf_wd         = wd_reg;
    assign bus.rf_rs         = rs_reg;
    assign bus.sp_out        = sp_reg;
    assign bus.stk_overflow  = ovf_reg;
    assign bus.stk_underflow = unf_reg;

    // Read data lands during POP_RSP; it is masked elsewhere so pop_data
    // stays zero outside the response cycle.
    assign bus.pop_valid = (state_reg == POP_RSP);
    assign bus.pop_data  = (state_reg == POP_RSP) ? bus.rf_rd[PCW-1:0] : '0;

    // Only the low PCW bits of a stack entry carry the return address.
    assign unused_rd_hi = ^bus.rf_rd[DW-1:PCW];

endmodule

// File: tb/tb_regfile_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regfile_ctrl
// Directed bench for regfile_ctrl with a behavioural 8x32 register file that
// has a registered read port. Inputs change 1 time unit after a rising edge;
// combinational readies are checked 1 unit later, registered outputs are
// checked right after each edge.
// -----------------------------------------------------------------------------
module tb_regfile_ctrl;
    import regfile_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    regfile_ctrl_if bus ();

    regfile_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Register file: write on rf_we, read data registered from rf_rs.
    logic [DW-1:0] rf_mem [8];
    always @(posedge clk) begin
        if (bus.rf_we) rf_mem[bus.rf_ws] <= bus.rf_wd;
        bus.rf_rd <= rf_mem[bus.rf_rs];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  pcs [4];
        logic [31:0] exps [4];
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
        bus.push_req = 1'b0; bus.pop_req = 1'b0; bus.push_pc = '0;

        // ---------------- reset state ----------------
        step(); step();
        chk("rst_sp", bus.sp_out, 7);
        chk("rst_we", bus.rf_we, 0);
        chk("rst_popv", bus.pop_valid, 0);
        reset = 1'b1;
        #1;
        chk("rel_sp", bus.sp_out, 7);
        chk("rel_wbr", bus.wb_ready, 0);
        chk("rel_ldr", bus.ld_ready, 0);
        chk("rel_stkr", bus.stk_ready, 0);
        step();
        chk("rel_we", bus.rf_we, 0);
        chk("rel_popv", bus.pop_valid, 0);
        $display("reset released sp=%0d", bus.sp_out);

        // ---------------- wb/ld round robin ----------------
        bus.wb_valid = 1'b1; bus.wb_addr = 3'd1; bus.wb_data = 32'hA;
        bus.ld_valid = 1'b1; bus.ld_addr = 3'd2; bus.ld_data = 32'hB;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_wbr", bus.wb_ready, (i % 2 == 0) ? 1 : 0);
            chk("rr_ldr", bus.ld_ready, (i % 2 == 1) ? 1 : 0);
            step();
            chk("rr_we", bus.rf_we, 1);
            chk("rr_ws", bus.rf_ws, (i % 2 == 0) ? 1 : 2);
            chk("rr_wd", bus.rf_wd, (i % 2 == 0) ? 32'hA : 32'hB);
            $display("rr cycle %0d write r%0d=%0h", i, bus.rf_ws, bus.rf_wd);
        end
        bus.wb_valid = 1'b0; bus.ld_valid = 1'b0;
        step();
        chk("rr_idle_we", bus.rf_we, 0);
        chk("rr_r1", rf_mem[1], 32'hA);
        chk("rr_r2", rf_mem[2], 32'hB);

        // ---------------- push 0x10, 0x20 ----------------
        bus.push_req = 1'b1; bus.push_pc = 8'h10;
        #1;
        chk("p1_rdy", bus.stk_ready, 1);
        step();
        bus.push_req = 1'b0;
        chk("p1_we", bus.rf_we, 1);
        chk("p1_ws", bus.rf_ws, 7);
        chk("p1_wd", bus.rf_wd, 32'h11);
        chk("p1_sp", bus.sp_out, 6);
        $display("push pc=10 -> r%0d=%0h", bus.rf_ws, bus.rf_wd);
        bus.push_req = 1'b1; bus.push_pc = 8'h20;
        #1;
        chk("p2_rdy", bus.stk_ready, 1);
        step();
        bus.push_req = 1'b0;
        chk("p2_ws", bus.rf_ws, 6);
        chk("p2_wd", bus.rf_wd, 32'h21);
        chk("p2_sp", bus.sp_out, 5);
        $display("push pc=20 -> r%0d=%0h", bus.rf_ws, bus.rf_wd);

        // ---------------- pop twice ----------------
        bus.pop_req = 1'b1;
        #1;
        chk("q1_rdy", bus.stk_ready, 1);
        step();
        #1;
        chk("q1_stall", bus.stk_ready, 0);
        chk("q1_sp", bus.sp_out, 6);
        chk("q1_rs", bus.rf_rs, 6);
        chk("q1_v0", bus.pop_valid, 0);
        bus.pop_req = 1'b0;
        step();
        chk("q1_v", bus.pop_valid, 1);
        chk("q1_data", bus.pop_data, 8'h21);
        $display("pop -> %0h", bus.pop_data);
        step();
        chk("q1_vend", bus.pop_valid, 0);
        bus.pop_req = 1'b1;
        #1;
        chk("q2_rdy", bus.stk_ready, 1);
        step();
        bus.pop_req = 1'b0;
        step();
        chk("q2_v", bus.pop_valid, 1);
        chk("q2_data", bus.pop_data, 8'h11);
        chk("q2_sp", bus.sp_out, 7);
        $display("pop -> %0h", bus.pop_data);
        step();

        // ---------------- fill stack, overflow ----------------
        pcs[0] = 8'h01; pcs[1] = 8'h7F; pcs[2] = 8'hFF; pcs[3] = 8'h30;
        exps[0] = 32'h02; exps[1] = 32'h80; exps[2] = 32'h00; exps[3] = 32'h31;
        for (int i = 0; i < 4; i++) begin
            bus.push_req = 1'b1; bus.push_pc = pcs[i];
            step();
            bus.push_req = 1'b0;
            chk("fill_ws", bus.rf_ws, 7 - i);
            chk("fill_wd", bus.rf_wd, exps[i]);
            $display("push pc=%0h -> r%0d=%0h", pcs[i], bus.rf_ws, bus.rf_wd);
        end
        chk("fill_sp", bus.sp_out, 3);
        bus.push_req = 1'b1; bus.push_pc = 8'h55;
        #1;
        chk("ovf_rdy", bus.stk_ready, 1);
        step();
        bus.push_req = 1'b0;
        chk("ovf_we", bus.rf_we, 0);
        chk("ovf_pulse", bus.stk_overflow, 1);
        chk("ovf_sp", bus.sp_out, 3);
        $display("push on full stack rejected");
        step();
        chk("ovf_end", bus.stk_overflow, 0);

        // ---------------- underflow after reset ----------------
        reset = 1'b0;
        step();
        chk("rst2_sp", bus.sp_out, 7);
        reset = 1'b1;
        bus.pop_req = 1'b1;
        #1;
        chk("unf_rdy", bus.stk_ready, 1);
        step();
        bus.pop_req = 1'b0;
        chk("unf_pulse", bus.stk_underflow, 1);
        chk("unf_sp", bus.sp_out, 7);
        $display("pop on empty stack rejected");
        step();
        chk("unf_end", bus.stk_underflow, 0);
        chk("unf_popv", bus.pop_valid, 0);

        // ---------------- push + pop + wb together ----------------
        bus.push_req = 1'b1; bus.push_pc = 8'h40;
        bus.pop_req  = 1'b1;
        bus.wb_valid = 1'b1; bus.wb_addr = 3'd3; bus.wb_data = 32'hC;
        #1;
        chk("mix_stkr", bus.stk_ready, 1);
        chk("mix_wbr0", bus.wb_ready, 0);
        step();
        bus.push_req = 1'b0;
        chk("mix_ws0", bus.rf_ws, 7);
        chk("mix_wd0", bus.rf_wd, 32'h41);
        #1;
        chk("mix_wbr1", bus.wb_ready, 1);
        chk("mix_popr", bus.stk_ready, 1);
        step();
        bus.wb_valid = 1'b0; bus.pop_req = 1'b0;
        chk("mix_ws1", bus.rf_ws, 3);
        chk("mix_wd1", bus.rf_wd, 32'hC);
        chk("mix_sp", bus.sp_out, 7);
        chk("mix_rs", bus.rf_rs, 7);
        step();
        chk("mix_v", bus.pop_valid, 1);
        chk("mix_data", bus.pop_data, 8'h41);
        $display("mixed: push r7, wb r3, pop -> %0h", bus.pop_data);
        step();

        // ---------------- reset during POP_RD ----------------
        bus.push_req = 1'b1; bus.push_pc = 8'h50;
        step();
        bus.push_req = 1'b0;
        bus.pop_req = 1'b1;
        step();
        bus.pop_req = 1'b0;
        reset = 1'b0;
        #1;
        chk("mrst_v0", bus.pop_valid, 0);
        step();
        chk("mrst_v1", bus.pop_valid, 0);
        chk("mrst_sp", bus.sp_out, 7);
        reset = 1'b1;
        step();
        chk("mrst_v2", bus.pop_valid, 0);
        bus.push_req = 1'b1; bus.push_pc = 8'h60;
        step();
        bus.push_req = 1'b0;
        chk("mrst_ws", bus.rf_ws, 7);
        chk("mrst_wd", bus.rf_wd, 32'h61);
        chk("mrst_sp2", bus.sp_out, 6);
        $display("reset mid-pop, then push -> r%0d=%0h", bus.rf_ws, bus.rf_wd);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
